// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: memory handshake FSM with timeout,
// priority-resolved freeze/flush generation and a saturating stall counter.
module pipeline_stall_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        has_hazard,
  input  logic        branch_taken,
  input  logic        mem_access,
  input  logic        mem_ready,
  output logic        freeze_IF,
  output logic        freeze_ID,
  output logic        freeze_EXE,
  output logic        freeze_MEM,
  output logic        flush_IF_ID,
  output logic        flush_ID_EXE,
  output logic        mem_start,
  output logic        mem_busy,
  output logic        timeout_err,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] WAIT_LAST = 5'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [4:0]  wait_cnt, wait_cnt_nxt;
  logic        timeout_q;
  logic [15:0] stall_q;
  logic        memfreeze;

  // State register, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (state != ERROR && state_nxt == ERROR)
        timeout_q <= 1'b1;
    end
  end

  // Next-state logic; mem_ready wins over the timeout in the last wait cycle
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      RUN: begin
        if (mem_access) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready)
          state_nxt = RUN;
        else if (wait_cnt == WAIT_LAST)
          state_nxt = ERROR;
        else
          wait_cnt_nxt = wait_cnt + 5'd1;
      end
      ERROR: state_nxt = ERROR;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Freeze/flush priority: memory, then taken branch, then data hazard
  always_comb begin
    memfreeze    = ((state == RUN) && mem_access) ||
                   ((state == MEM_WAIT) && !mem_ready) ||
                   (state == ERROR);
    mem_start    = (state == RUN) && mem_access;
    freeze_IF    = 1'b0;
    freeze_ID    = 1'b0;
    freeze_EXE   = 1'b0;
    freeze_MEM   = 1'b0;
    flush_IF_ID  = 1'b0;
    flush_ID_EXE = 1'b0;
    if (memfreeze) begin
      freeze_IF  = 1'b1;
      freeze_ID  = 1'b1;
      freeze_EXE = 1'b1;
      freeze_MEM = 1'b1;
    end else if (branch_taken) begin
      flush_IF_ID  = 1'b1;
      flush_ID_EXE = 1'b1;
    end else if (has_hazard) begin
      freeze_IF    = 1'b1;
      freeze_ID    = 1'b1;
      flush_ID_EXE = 1'b1;
    end
  end

  // Saturating count of cycles with the front end frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (freeze_IF && stall_q != '1)
      stall_q <= stall_q + 16'd1;
  end

  assign mem_busy    = (state == MEM_WAIT);
  assign timeout_err = timeout_q;
  assign stall_count = stall_q;

endmodule
